crossbar_hier_one_hot_cfg: RTL
==============================

# crossbar_hier_one_hot_cfg

Parametrised two-level pipelined crossbar. Routes NUM_INPUT_DATA input lanes to NUM_OUTPUT_DATA output lanes through NUM_GROUPS first-stage group crossbars and a per-output group-select stage. Routing comes from a stored one-hot configuration register with per-output error detection, instead of a free-running command bus. It sits between the ingress lanes and the per-output consumers in the hierarchical NoC, replacing the fixed 16-in/8-out crossbar.

## Interface
- DATA_WIDTH, 32: bits per lane; any value ≥1.
- NUM_INPUT_DATA, 16: input lanes; must be a multiple of NUM_GROUPS.
- NUM_OUTPUT_DATA, 8: output lanes; ≥1.
- NUM_GROUPS, 2: first-stage groups; ≥1, power of 2.
- IN_PIPE_STAGES, 5: input wire-pipeline depth; 0..8.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  NUM_INPUT_DATA  per-input-lane valid.
- i_data_bus  in  NUM_INPUT_DATA*DATA_WIDTH  input lane n at [n*DATA_WIDTH +: DATA_WIDTH].
- i_en  in  1  traffic enable; pipelined alongside data.
- i_cmd_load  in  1  load i_cmd into the configuration register.
- i_cmd  in  NUM_INPUT_DATA*NUM_OUTPUT_DATA  bit [n*NUM_OUTPUT_DATA+m] connects input n to output m.
- o_valid  out  NUM_OUTPUT_DATA  per-output valid.
- o_data_bus  out  NUM_OUTPUT_DATA*DATA_WIDTH  output lane m at [m*DATA_WIDTH +: DATA_WIDTH].
- o_cmd_err  out  NUM_OUTPUT_DATA  output m's column in the configuration has more than one bit set.

## Operation
- Configuration register cfg (NUM_INPUT_DATA*NUM_OUTPUT_DATA bits):
  - Loaded from i_cmd on any cycle with i_cmd_load=1.
  - Holds its value otherwise.
  - Reset value is all zeros: every output disconnected.
- Column m is the bits cfg[n*NUM_OUTPUT_DATA+m] for all n. Each column is classified as:
  - zero: output m idle, o_valid[m]=0, data 0.
  - one-hot: input n drives output m.
  - multi-hot: output m is forced idle and o_cmd_err[m]=1.
- Fan-out is allowed: one input may drive several outputs.
- Input pipeline: i_valid, i_data_bus and i_en pass through IN_PIPE_STAGES register stages. rst clears every valid and en bit; data bits are also cleared to 0.
- Stage 1: each group g covers inputs [g*G, (g+1)*G), where G = NUM_INPUT_DATA/NUM_GROUPS. For each output m, group g registers:
  - valid = OR over n in the group of (cfg bit AND pipelined valid[n]).
  - data = pipelined data of the selected input when valid, else 0.
- Stage 2: for each output m, the group index comes from cfg, not from valid.
  - o_valid[m] and o_data_bus lane m are registered from that group's stage-1 result.
  - Idle or multi-hot columns register valid 0 and data 0.
- Enable: when the pipelined en reaching a stage is 0, that stage registers valid 0 and data 0. Disable drains as bubbles with the same latency as data.
- Output data is always 0 whenever the corresponding valid is 0.

## Timing
- Data latency: IN_PIPE_STAGES+2 cycles from i_valid/i_data_bus to o_valid/o_data_bus. Throughput is one word per lane per cycle.
- cfg update: cfg changes at the edge where i_cmd_load=1.
  - Stage 1 and stage 2 use the new cfg from the next cycle on.
  - In-flight data in stages 1–2 at that moment can be routed under mixed configurations. Software must drain (i_en=0 for IN_PIPE_STAGES+2 cycles) before reloading if this matters.
- o_cmd_err is registered from cfg and valid 1 cycle after the load edge.
- rst has priority over i_cmd_load in the same cycle. All outputs read 0 on the cycle after rst is sampled high.
- rst mid-traffic: the pipeline flushes in one cycle, with no residual valids afterwards.
- IN_PIPE_STAGES=0: the input pipeline is wires; latency is 2.

## Structure
- Shared package: lane-index and column-index helper functions (cfg bit index = n*NUM_OUTPUT_DATA+m) and parameter legality checks (divisibility, power of 2), raised as elaboration errors.
- Sub-module crossbar_group_onehot_mux: one group × all outputs. Holds the stage-1 registers, sized by group size G, with cfg column slices as inputs.
- The top instantiates NUM_GROUPS of these plus the input pipeline, cfg/error registers and stage 2.

## Test plan
- Defaults, load identity-plus-8 (input n→output n mod 8 for n<8), stream i_data lane n = 0xA000_000n with valid=1 → o_data lane m = 0xA000_000m exactly 7 cycles later, o_cmd_err=0.
- Load input 12 → outputs 0..7 (fan-out), valid on lane 12 only with 0xDEAD_BEEF → all 8 outputs valid with 0xDEAD_BEEF; lane 12 valid=0 → all outputs valid=0 with data 0.
- Load column 3 with inputs 2 and 9 set → o_cmd_err=8'b0000_1000 one cycle after load; o_valid[3] stays 0 under full traffic while the other outputs route normally.
- Drop i_en for 3 cycles mid-stream → exactly 3 bubble cycles (valid 0, data 0) appear at the output 7 cycles later, with no lost or duplicated words.
- Assert rst with i_cmd_load=1 during traffic → next cycle o_valid=0, o_data_bus=0, o_cmd_err=0; cfg=0, so no output goes valid until a new load.
- Rebuild with NUM_GROUPS=4, IN_PIPE_STAGES=0, DATA_WIDTH=8 and repeat scenario 1 → latency 2.

Source files
------------

// File: rtl/crossbar_hier_one_hot_cfg_pkg.sv
// Shared helpers for the hierarchical one-hot crossbar: bit/lane index math and
// parameter legality checks evaluated at elaboration.
package crossbar_hier_one_hot_cfg_pkg;

  // Configuration bit that connects input n to output m.
  function automatic int cfg_idx(input int n, input int m, input int num_out);
    return n * num_out + m;
  endfunction

  // Low bit of lane n on a bus of width-w lanes.
  function automatic int lane_lo(input int n, input int w);
    return n * w;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int data_width, input int num_in, input int num_out,
                                   input int num_groups, input int pipe_stages);
    return (data_width >= 1) && (num_out >= 1) && is_pow2(num_groups) &&
           (num_in >= num_groups) && ((num_in % num_groups) == 0) &&
           (pipe_stages >= 0) && (pipe_stages <= 8);
  endfunction

endpackage

// File: rtl/crossbar_group_onehot_mux.sv
// Stage 1 of the crossbar: one input group against every output, registering a
// per-output valid and the selected lane's data (zero when not valid).
module crossbar_group_onehot_mux
  import crossbar_hier_one_hot_cfg_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int GROUP_SIZE      = 8,
  parameter int NUM_OUTPUT_DATA = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [GROUP_SIZE-1:0]                 valid,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]      data_bus,
  // Bit m*GROUP_SIZE+j: group input j drives output m.
  input  logic [NUM_OUTPUT_DATA*GROUP_SIZE-1:0] col_sel,
  output logic [NUM_OUTPUT_DATA-1:0]            s1_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] s1_data_bus
);

  logic [NUM_OUTPUT_DATA-1:0]            nxt_valid;
  logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] nxt_data;

  always_comb begin
    // NOTE: defaults first so every path assigns every bit; otherwise a latch is inferred.
    nxt_valid = '0;
    nxt_data  = '0;
    for (int m = 0; m < NUM_OUTPUT_DATA; m++) begin
      for (int j = 0; j < GROUP_SIZE; j++) begin
        if (col_sel[m*GROUP_SIZE + j] && valid[j]) begin
          nxt_valid[m] = 1'b1;
          nxt_data[lane_lo(m, DATA_WIDTH) +: DATA_WIDTH] |=
            data_bus[lane_lo(j, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
    end
  end

  // NOTE: registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      s1_valid    <= '0;
      s1_data_bus <= '0;
    end else begin
      s1_valid    <= nxt_valid;
      s1_data_bus <= nxt_data;
    end
  end

endmodule

// File: rtl/crossbar_hier_one_hot_cfg.sv
// Two-level pipelined crossbar routed by a stored one-hot configuration register;
// multi-hot output columns are forced idle and flagged on o_cmd_err.
module crossbar_hier_one_hot_cfg
  import crossbar_hier_one_hot_cfg_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_INPUT_DATA  = 16,
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int NUM_GROUPS      = 2,
  parameter int IN_PIPE_STAGES  = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_INPUT_DATA-1:0]             i_valid,
  input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]  i_data_bus,
  input  logic                                  i_en,
  input  logic                                  i_cmd_load,
  input  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] i_cmd,
  output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
  output logic [NUM_OUTPUT_DATA-1:0]            o_cmd_err
);

  localparam int NI = NUM_INPUT_DATA;
  localparam int NO = NUM_OUTPUT_DATA;
  localparam int W  = DATA_WIDTH;
  localparam int G  = NUM_INPUT_DATA / NUM_GROUPS;

  if (!params_ok(DATA_WIDTH, NUM_INPUT_DATA, NUM_OUTPUT_DATA, NUM_GROUPS, IN_PIPE_STAGES)) begin : g_bad_params
    $error("crossbar_hier_one_hot_cfg: illegal parameter combination");
  end

  logic [NI-1:0]   p_valid;
  logic [NI*W-1:0] p_data;
  logic            p_en;

  if (IN_PIPE_STAGES == 0) begin : g_no_pipe
    assign p_valid = i_valid;
    assign p_data  = i_data_bus;
    assign p_en    = i_en;
  end else begin : g_pipe
    logic [NI-1:0]   valid_q [IN_PIPE_STAGES];
    logic [NI*W-1:0] data_q  [IN_PIPE_STAGES];
    logic [IN_PIPE_STAGES-1:0] en_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        en_q <= '0;
        // NOTE: the data stages are reset too, so no stale word can ever surface after rst.
        for (int s = 0; s < IN_PIPE_STAGES; s++) begin
          valid_q[s] <= '0;
          data_q[s]  <= '0;
        end
      end else begin
        valid_q[0] <= i_valid;
        data_q[0]  <= i_data_bus;
        en_q[0]    <= i_en;
        for (int s = 1; s < IN_PIPE_STAGES; s++) begin
          valid_q[s] <= valid_q[s-1];
          data_q[s]  <= data_q[s-1];
          en_q[s]    <= en_q[s-1];
        end
      end
    end

    assign p_valid = valid_q[IN_PIPE_STAGES-1];
    assign p_data  = data_q[IN_PIPE_STAGES-1];
    assign p_en    = en_q[IN_PIPE_STAGES-1];
  end

  logic [NI*NO-1:0] cfg;
  logic [NO-1:0]    multi_hot;
  logic [NO*G-1:0]  grp_col [NUM_GROUPS];
  logic [NO-1:0]    grp_hit [NUM_GROUPS];

  always_comb begin
    multi_hot = '0;
    for (int m = 0; m < NO; m++) begin
      automatic logic seen = 1'b0;
      for (int n = 0; n < NI; n++) begin
        if (cfg[cfg_idx(n, m, NO)]) begin
          if (seen) multi_hot[m] = 1'b1;
          seen = 1'b1;
        end
      end
    end
  end

  // Regroup each output column into per-group slices for the stage-1 muxes.
  always_comb begin
    grp_col = '{default: '0};
    grp_hit = '{default: '0};
    for (int g = 0; g < NUM_GROUPS; g++) begin
      for (int m = 0; m < NO; m++) begin
        for (int j = 0; j < G; j++) begin
          grp_col[g][m*G + j] = cfg[cfg_idx(g*G + j, m, NO)];
        end
        grp_hit[g][m] = |grp_col[g][m*G +: G];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg       <= '0;
      o_cmd_err <= '0;
    end else begin
      if (i_cmd_load) cfg <= i_cmd;
      o_cmd_err <= multi_hot;
    end
  end

  logic [NO-1:0]   s1_valid [NUM_GROUPS];
  logic [NO*W-1:0] s1_data  [NUM_GROUPS];
  logic            s1_en;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
    crossbar_group_onehot_mux #(
      .DATA_WIDTH      (W),
      .GROUP_SIZE      (G),
      .NUM_OUTPUT_DATA (NO)
    ) u_group (
      .clk         (clk),
      .rst         (rst),
      .en          (p_en),
      .valid       (p_valid[g*G +: G]),
      .data_bus    (p_data[g*G*W +: G*W]),
      .col_sel     (grp_col[g]),
      .s1_valid    (s1_valid[g]),
      .s1_data_bus (s1_data[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) s1_en <= 1'b0;
    else     s1_en <= p_en;
  end

  // Stage 2: the group is chosen by which slice of the column is set, never by valid.
  logic [NO-1:0]   s2_valid;
  logic [NO*W-1:0] s2_data;

  always_comb begin
    s2_valid = '0;
    s2_data  = '0;
    for (int m = 0; m < NO; m++) begin
      if (!multi_hot[m]) begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
          if (grp_hit[g][m]) begin
            s2_valid[m]                   = s1_valid[g][m];
            s2_data[lane_lo(m, W) +: W]   = s1_data[g][lane_lo(m, W) +: W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !s1_en) begin
      o_valid    <= '0;
      o_data_bus <= '0;
    end else begin
      o_valid    <= s2_valid;
      o_data_bus <= s2_data;
    end
  end

endmodule
